uart_tx_fifo: RTL and testbench

- Byte buffer and flow-control stage directly upstream of the UART transmitter.
- Accepts bytes from a producer (CPU/logic) through a single-cycle write strobe and stores them in a circular FIFO.
- Drains the FIFO one byte per frame by driving the transmitter's uart_en / uart_din inputs, pacing on its uart_tx_busy output.
- Decouples bursty producers from the serial line rate.

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: buffers producer writes and issues one
// uart_en strobe per byte, paced by uart_tx_busy. Define UART_TX_CRLF_EN to expand LF into CR LF.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  wr_overflow,
    output logic                  uart_en,
    output logic [7:0]            uart_din,
    input  logic                  uart_tx_busy,
    output logic                  tx_idle
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic [7:0]            uart_din_q, uart_din_d;
    logic                  wr_overflow_q, wr_overflow_d;
    logic                  push;
    logic                  pop;
`ifdef UART_TX_CRLF_EN
    logic                  pending_lf_q, pending_lf_d;
`endif

    // Full/empty come from the registered level, so a pop never frees a slot for the same-cycle write.
    assign fifo_full   = (level_q == LVL_FULL);
    assign fifo_empty  = (level_q == '0);
    assign fifo_level  = level_q;
    assign wr_overflow = wr_overflow_q;
    assign uart_en     = (state_q == PULSE);
    assign uart_din    = uart_din_q;
    assign tx_idle     = (state_q == IDLE) && fifo_empty && !uart_tx_busy;

    assign push = wr_en && !fifo_full;

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        uart_din_d = uart_din_q;
        pop        = 1'b0;
`ifdef UART_TX_CRLF_EN
        pending_lf_d = pending_lf_q;
`endif
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = PULSE;
`ifdef UART_TX_CRLF_EN
                    if (pending_lf_q) begin
                        uart_din_d   = 8'h0A;
                        pop          = 1'b1;
                        pending_lf_d = 1'b0;
                    end else if (mem[rd_ptr_q] == 8'h0A) begin
                        // Send CR first and leave the LF at the head for the next frame.
                        uart_din_d   = 8'h0D;
                        pending_lf_d = 1'b1;
                    end else begin
                        uart_din_d = mem[rd_ptr_q];
                        pop        = 1'b1;
                    end
`else
                    uart_din_d = mem[rd_ptr_q];
                    pop        = 1'b1;
`endif
                end
            end
            PULSE: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Busy is already high in the strobe cycle, so sampling it right away is safe.
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        wr_overflow_d = wr_en && fifo_full;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            uart_din_q    <= 8'h00;
            wr_overflow_q <= 1'b0;
`ifdef UART_TX_CRLF_EN
            pending_lf_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            uart_din_q    <= uart_din_d;
            wr_overflow_q <= wr_overflow_d;
`ifdef UART_TX_CRLF_EN
            pending_lf_q  <= pending_lf_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a simple busy model of the downstream transmitter.
module tb_uart_tx_fifo;

    localparam int DL       = 4;
    localparam int DEPTH    = 16;
    localparam int BUSY_LEN = 20;

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          fifo_full;
    logic          fifo_empty;
    logic [DL:0]   fifo_level;
    logic          wr_overflow;
    logic          uart_en;
    logic [7:0]    uart_din;
    logic          uart_tx_busy;
    logic          tx_idle;

    logic          busy_force = 1'b0;
    int            busy_cnt = 0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    int            ovf_cnt = 0;
    logic          prev_en = 1'b0;
    logic [7:0]    q_data[$];
    int            q_cyc[$];
    logic [7:0]    exp_data[$];

    uart_tx_fifo #(.DEPTH_LOG2(DL)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .fifo_level   (fifo_level),
        .wr_overflow  (wr_overflow),
        .uart_en      (uart_en),
        .uart_din     (uart_din),
        .uart_tx_busy (uart_tx_busy),
        .tx_idle      (tx_idle)
    );

    always #5 sys_clk = ~sys_clk;

    // Transmitter model: busy in the strobe cycle and BUSY_LEN-1 cycles after it.
    assign uart_tx_busy = uart_en | (busy_cnt != 0) | busy_force;

    always @(posedge sys_clk) begin
        cyc <= cyc + 1;
        if (uart_en) begin
            busy_cnt <= BUSY_LEN - 1;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    always @(negedge sys_clk) begin
        if (uart_en) begin
            q_data.push_back(uart_din);
            q_cyc.push_back(cyc);
            n_cmp++;
            assert (prev_en === 1'b0) else begin
                n_err++;
                $error("FAIL en_gap: observed back-to-back uart_en at cycle %0d, expected a low cycle between", cyc);
            end
        end
        if (wr_overflow) begin
            ovf_cnt++;
        end
        prev_en = uart_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: inputs change just after the rising edge, checks happen at the falling edge.
    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge sys_clk);
    endtask

    task automatic wait_idle(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            sample();
            if (tx_idle === 1'b1) break;
        end
        chk("idle_timeout", {31'd0, tx_idle}, 32'd1);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_count"}, q_data.size(), exp_data.size());
        for (int i = 0; i < exp_data.size() && i < q_data.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), {24'd0, q_data[i]}, {24'd0, exp_data[i]});
        end
    endtask

    initial begin
        int ovf_base;

        // Reset state
        step(); step();
        sample();
        chk("rst_uart_en", {31'd0, uart_en}, 32'd0);
        chk("rst_uart_din", {24'd0, uart_din}, 32'h00);
        chk("rst_empty", {31'd0, fifo_empty}, 32'd1);
        chk("rst_full", {31'd0, fifo_full}, 32'd0);
        chk("rst_level", {27'd0, fifo_level}, 32'd0);
        chk("rst_tx_idle", {31'd0, tx_idle}, 32'd1);
        chk("rst_ovf", {31'd0, wr_overflow}, 32'd0);
        step(); sys_rst = 1'b0;
        step();
        $display("reset: checked idle outputs");

        // Single byte latency
        q_data.delete(); q_cyc.delete();
        step(); wr_en = 1'b1; wr_data = 8'h55;
        sample();
        chk("t2_c0_empty", {31'd0, fifo_empty}, 32'd1);
        step(); wr_en = 1'b0;
        sample();
        chk("t2_c1_empty", {31'd0, fifo_empty}, 32'd0);
        chk("t2_c1_level", {27'd0, fifo_level}, 32'd1);
        chk("t2_c1_en", {31'd0, uart_en}, 32'd0);
        step(); sample();
        chk("t2_c2_en", {31'd0, uart_en}, 32'd1);
        chk("t2_c2_din", {24'd0, uart_din}, 32'h55);
        chk("t2_c2_level", {27'd0, fifo_level}, 32'd0);
        step(); sample();
        chk("t2_c3_en", {31'd0, uart_en}, 32'd0);
        chk("t2_c3_din", {24'd0, uart_din}, 32'h55);
        chk("t2_c3_idle", {31'd0, tx_idle}, 32'd0);
        wait_idle(100);
        exp_data = '{8'h55};
        chk_stream("t2");
        $display("single byte 55: pulses=%0d", q_data.size());

        // Burst of three bytes
        q_data.delete(); q_cyc.delete();
        step(); wr_en = 1'b1; wr_data = 8'h41;
        sample(); chk("t3_c0_level", {27'd0, fifo_level}, 32'd0);
        step(); wr_data = 8'h42;
        sample(); chk("t3_c1_level", {27'd0, fifo_level}, 32'd1);
        step(); wr_data = 8'h43;
        sample(); chk("t3_c2_level", {27'd0, fifo_level}, 32'd1);
        chk("t3_c2_en", {31'd0, uart_en}, 32'd1);
        step(); wr_en = 1'b0;
        sample(); chk("t3_c3_level", {27'd0, fifo_level}, 32'd2);
        wait_idle(200);
        exp_data = '{8'h41, 8'h42, 8'h43};
        chk_stream("t3");
        for (int i = 1; i < q_cyc.size(); i++) begin
            chk($sformatf("t3_gap%0d", i), q_cyc[i] - q_cyc[i-1], BUSY_LEN + 2);
        end
        $display("burst 41,42,43: pulses=%0d", q_data.size());

        // Fill to full while the transmitter is stalled
        q_data.delete(); q_cyc.delete();
        step(); wr_en = 1'b1; wr_data = 8'hEE;
        step(); wr_en = 1'b0;
        step();
        step(); busy_force = 1'b1;
        ovf_base = ovf_cnt;
        for (int i = 0; i < DEPTH + 2; i++) begin
            step(); wr_en = 1'b1; wr_data = 8'(i + 1);
            sample();
            if (i == DEPTH - 1) begin
                chk("t4_full_before", {31'd0, fifo_full}, 32'd0);
                chk("t4_level_before", {27'd0, fifo_level}, 32'd15);
            end
            if (i == DEPTH) begin
                chk("t4_full_at16", {31'd0, fifo_full}, 32'd1);
                chk("t4_level_at16", {27'd0, fifo_level}, 32'd16);
                chk("t4_ovf_before", {31'd0, wr_overflow}, 32'd0);
            end
            if (i == DEPTH + 1) begin
                chk("t4_ovf_first", {31'd0, wr_overflow}, 32'd1);
            end
        end
        step(); wr_en = 1'b0;
        sample();
        chk("t4_ovf_second", {31'd0, wr_overflow}, 32'd1);
        chk("t4_level_after", {27'd0, fifo_level}, 32'd16);
        step(); sample();
        chk("t4_ovf_end", {31'd0, wr_overflow}, 32'd0);
        chk("t4_ovf_count", ovf_cnt - ovf_base, 32'd2);
        busy_force = 1'b0;
        wait_idle(600);
        exp_data.delete();
        exp_data.push_back(8'hEE);
        for (int i = 1; i <= DEPTH; i++) exp_data.push_back(8'(i));
        chk_stream("t4");
        $display("overflow fill: pulses=%0d overflows=%0d", q_data.size(), ovf_cnt - ovf_base);

        // Reset while holding with five bytes queued
        step(); wr_en = 1'b1; wr_data = 8'h60;
        step(); wr_en = 1'b0;
        step();
        step(); busy_force = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(); wr_en = 1'b1; wr_data = 8'(8'h61 + i);
        end
        step(); wr_en = 1'b0;
        sample();
        chk("t5_level_pre", {27'd0, fifo_level}, 32'd5);
        chk("t5_din_pre", {24'd0, uart_din}, 32'h60);
        q_data.delete(); q_cyc.delete();
        step(); sys_rst = 1'b1;
        step(); sys_rst = 1'b0;
        sample();
        chk("t5_level", {27'd0, fifo_level}, 32'd0);
        chk("t5_empty", {31'd0, fifo_empty}, 32'd1);
        chk("t5_en", {31'd0, uart_en}, 32'd0);
        chk("t5_din", {24'd0, uart_din}, 32'h00);
        chk("t5_idle_busy", {31'd0, tx_idle}, 32'd0);
        step(); busy_force = 1'b0;
        for (int i = 0; i < 40; i++) step();
        sample();
        chk("t5_idle_after", {31'd0, tx_idle}, 32'd1);
        chk("t5_no_pulses", q_data.size(), 32'd0);
        $display("reset in hold: pulses after reset=%0d", q_data.size());

        // LF handling
        q_data.delete(); q_cyc.delete();
        step(); wr_en = 1'b1; wr_data = 8'h0A;
        step(); wr_data = 8'h31;
        step(); wr_en = 1'b0;
        wait_idle(200);
`ifdef UART_TX_CRLF_EN
        exp_data = '{8'h0D, 8'h0A, 8'h31};
`else
        exp_data = '{8'h0A, 8'h31};
`endif
        chk_stream("t6");
        $display("lf stream: pulses=%0d", q_data.size());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish within 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
